// File: rtl/alu_pkg.sv
// Shared definitions for the multicycle ALU and whatever controller drives it.
// Holds the operation encoding, the controller state encoding and the width of
// the shift-amount counter.
package alu_pkg;

  localparam int SHAMT_W = 5;

  typedef enum logic [3:0] {
    OP_AND    = 4'b0000,
    OP_OR     = 4'b0001,
    OP_ADD    = 4'b0010,
    OP_SUB    = 4'b0011,
    OP_XOR    = 4'b0100,
    OP_SRL    = 4'b0101,
    OP_SLL    = 4'b0110,
    OP_SRA    = 4'b0111,
    OP_EQ     = 4'b1000,
    OP_PASS_B = 4'b1010,
    OP_SLT    = 4'b1110
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } alu_state_e;

  // Shifts run one bit per cycle; every other operation completes on acceptance.
  function automatic logic is_shift(alu_op_e op);
    return (op == OP_SRL) || (op == OP_SLL) || (op == OP_SRA);
  endfunction

endpackage

// File: rtl/multicycle_alu_if.sv
// Request/response bundle between an ALU controller (master) and the
// multicycle ALU (slave).
//   in_valid/in_ready   : request handshake, Operation/SrcA/SrcB travel with it
//   out_valid/out_ready : response handshake, ALUResult/Zero travel with it
interface multicycle_alu_if
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  alu_op_e          Operation;
  logic [WIDTH-1:0] SrcA;
  logic [WIDTH-1:0] SrcB;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] ALUResult;
  logic             Zero;

  modport master (
    output in_valid, Operation, SrcA, SrcB, out_ready,
    input  in_ready, out_valid, ALUResult, Zero
  );

  modport slave (
    input  in_valid, Operation, SrcA, SrcB, out_ready,
    output in_ready, out_valid, ALUResult, Zero
  );
endinterface

// File: rtl/alu_shift_step.sv
// One-bit combinational shift step used while the ALU sits in SHIFT.
//   data_i : working register
//   op_i   : OP_SRL (zero fill), OP_SLL (zero fill), OP_SRA (sign fill)
//   data_o : data_i moved by one bit; passes through for any other op
module alu_shift_step
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] data_i,
  input  alu_op_e          op_i,
  output logic [WIDTH-1:0] data_o
);
  always_comb begin
    case (op_i)
      OP_SRL:  data_o = {1'b0, data_i[WIDTH-1:1]};
      OP_SLL:  data_o = {data_i[WIDTH-2:0], 1'b0};
      OP_SRA:  data_o = {data_i[WIDTH-1], data_i[WIDTH-1:1]};
      default: data_o = data_i;
    endcase
  end
endmodule

// File: rtl/multicycle_alu.sv
// Multicycle ALU. Logic/arithmetic ops finish in one cycle; shifts walk the
// operand one bit per cycle through alu_shift_step.
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : multicycle_alu_if slave (request in, result out)
module multicycle_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic             clk,
  input logic             reset,
  multicycle_alu_if.slave bus
);

  alu_state_e         state_q, state_d;
  alu_op_e            op_q, op_d;
  logic [WIDTH-1:0]   work_q, work_d;
  logic [SHAMT_W-1:0] shamt_q, shamt_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   step_out;

  function automatic logic [WIDTH-1:0] alu_eval(alu_op_e op, logic [WIDTH-1:0] a,
                                                logic [WIDTH-1:0] b);
    case (op)
      OP_AND:    return a & b;
      OP_OR:     return a | b;
      OP_ADD:    return a + b;
      OP_SUB:    return a - b;
      OP_XOR:    return a ^ b;
      OP_EQ:     return WIDTH'(a == b);
      OP_PASS_B: return b;
      OP_SLT:    return WIDTH'($signed(a) < $signed(b));
      default:   return '0;  // undefined codes; shifts never take this path
    endcase
  endfunction

  alu_shift_step #(.WIDTH(WIDTH)) u_shift_step (
    .data_i (work_q),
    .op_i   (op_q),
    .data_o (step_out)
  );

  always_comb begin
    // NOTE: every next-state value starts as a copy of its flop so no path
    // through the case statement can leave one unassigned and infer a latch.
    state_d  = state_q;
    op_d     = op_q;
    work_d   = work_q;
    shamt_d  = shamt_q;
    result_d = result_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          op_d = bus.Operation;
          if (is_shift(bus.Operation)) begin
            work_d  = bus.SrcA;
            shamt_d = bus.SrcB[SHAMT_W-1:0];
            if (bus.SrcB[SHAMT_W-1:0] == '0) begin
              result_d = bus.SrcA;
              state_d  = DONE;
            end else begin
              state_d = SHIFT;
            end
          end else begin
            result_d = alu_eval(bus.Operation, bus.SrcA, bus.SrcB);
            state_d  = DONE;
          end
        end
      end
      SHIFT: begin
        work_d  = step_out;
        shamt_d = shamt_q - SHAMT_W'(1);
        // Last step: capture directly so the result appears with the DONE state.
        if (shamt_q == SHAMT_W'(1)) begin
          result_d = step_out;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Handshake flags are decoded from the next state so they are registered.
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state_q     <= IDLE;
      op_q        <= OP_AND;
      work_q      <= '0;
      shamt_q     <= '0;
      result_q    <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      work_q      <= work_d;
      shamt_q     <= shamt_d;
      result_q    <= result_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.ALUResult = result_q;
  assign bus.Zero      = (result_q == '0);

endmodule

// File: tb/tb_multicycle_alu.sv
// Scoreboard bench for multicycle_alu: the driver pushes the expected result and
// the cycle at which out_valid must first appear; a monitor pops and compares
// whenever the DUT presents a result.
module tb_multicycle_alu;
  import alu_pkg::*;

  typedef struct {
    logic [31:0] res;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  multicycle_alu_if #(.WIDTH(32)) bus ();

  multicycle_alu #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb[$];
  exp_t cur;
  bit   holding = 1'b0;
  bit   rand_ready = 1'b0;
  bit   ready_force = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: the arithmetic meaning of each opcode.
  function automatic logic [31:0] ref_alu(logic [3:0] op, logic [31:0] a, logic [31:0] b);
    int sh;
    sh = int'(b[4:0]);
    case (op)
      4'h0: return a & b;
      4'h1: return a | b;
      4'h2: return a + b;
      4'h3: return a - b;
      4'h4: return a ^ b;
      4'h5: return a >> sh;
      4'h6: return a << sh;
      4'h7: return $unsigned($signed(a) >>> sh);
      4'h8: return (a == b) ? 32'd1 : 32'd0;
      4'hA: return b;
      4'hE: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  // Consumer: random backpressure or a forced level, changed away from the edge.
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      bus.out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_force;
    end
  end

  // Monitor
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        holding = 1'b0;
      end else if (bus.out_valid) begin
        if (!holding) begin
          if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_out_valid: got result %h with empty scoreboard (cycle %0d)",
                     bus.ALUResult, cyc);
          end else begin
            cur = sb.pop_front();
            holding = 1'b1;
            check("latency", cyc, cur.due);
            check("result", bus.ALUResult, cur.res);
            check("zero", {31'd0, bus.Zero}, {31'd0, cur.res == 32'd0});
          end
        end else begin
          check("hold_result", bus.ALUResult, cur.res);
        end
        check("in_ready_while_done", {31'd0, bus.in_ready}, 32'd0);
        if (bus.out_ready) holding = 1'b0;
      end
    end
  end

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit push, output int acc);
    int w;
    w = 0;
    @(negedge clk);
    while (!bus.in_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!bus.in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL issue_timeout: in_ready got 0 expected 1 (cycle %0d)", cyc);
      acc = -1;
      return;
    end
    bus.in_valid  = 1'b1;
    bus.Operation = alu_op_e'(op);
    bus.SrcA      = a;
    bus.SrcB      = b;
    acc = cyc;
    if (push)
      sb.push_back('{res: ref_alu(op, a, b),
                     due: acc + 1 + ((op >= 4'h5 && op <= 4'h7) ? int'(b[4:0]) : 0)});
    @(negedge clk);
    // Scramble the request lines: the accepted operation must not notice.
    bus.in_valid  = 1'b0;
    bus.Operation = alu_op_e'(4'($urandom_range(0, 15)));
    bus.SrcA      = $urandom;
    bus.SrcB      = $urandom;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((sb.size() != 0 || holding) && w < 2000) begin
      @(negedge clk);
      w++;
    end
    check("drain_empty", sb.size(), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int acc;
    int w;
    bus.in_valid  = 1'b0;
    bus.Operation = OP_AND;
    bus.SrcA      = '0;
    bus.SrcB      = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("reset_result", bus.ALUResult, 32'd0);
    check("reset_zero", {31'd0, bus.Zero}, 32'd1);
    reset = 1'b0;

    // Directed operations
    issue(4'h2, 32'h0000_0005, 32'h0000_0003, 1'b1, acc);  // ADD -> 8
    issue(4'h3, 32'h0000_1234, 32'h0000_1234, 1'b1, acc);  // SUB -> 0
    issue(4'h8, 32'h0000_1234, 32'h0000_1234, 1'b1, acc);  // EQ  -> 1
    issue(4'h7, 32'h8000_0000, 32'd4, 1'b1, acc);          // SRA -> F8000000, latency 5
    issue(4'h6, 32'hDEAD_BEEF, 32'd0, 1'b1, acc);          // SLL by 0 -> A, latency 1
    issue(4'hE, 32'hFFFF_FFFF, 32'd1, 1'b1, acc);          // SLT -> 1
    issue(4'hF, 32'hA5A5_0001, 32'h1234_5678, 1'b1, acc);  // undefined -> 0
    issue(4'h5, 32'hF000_0000, 32'd31, 1'b1, acc);         // SRL by max amount
    drain();

    // Backpressure: result held for three cycles while in_valid pulses are ignored
    ready_force = 1'b0;
    @(negedge clk);
    issue(4'h4, 32'h0F0F_0F0F, 32'hFFFF_0000, 1'b1, acc);
    w = 0;
    while (!bus.out_valid && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("bp_reached_done", {31'd0, bus.out_valid}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      bus.in_valid  = 1'b1;
      bus.Operation = OP_OR;
      bus.SrcA      = $urandom;
      bus.SrcB      = $urandom;
      @(negedge clk);
      check("bp_in_ready_low", {31'd0, bus.in_ready}, 32'd0);
    end
    bus.in_valid = 1'b0;
    ready_force  = 1'b1;
    w = 0;
    while (!(bus.out_valid && bus.out_ready) && w < 50) begin
      @(negedge clk);
      w++;
    end
    @(negedge clk);
    check("bp_release_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("bp_release_out_valid", {31'd0, bus.out_valid}, 32'd0);

    // Reset during SHIFT abandons the operation
    issue(4'h6, 32'h1357_9BDF, 32'd20, 1'b0, acc);
    w = 0;
    while (cyc < acc + 5 && w < 50) begin
      @(negedge clk);
      w++;
    end
    reset = 1'b1;
    @(negedge clk);
    check("rst_shift_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_shift_result", bus.ALUResult, 32'd0);
    check("rst_shift_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("rst_shift_zero", {31'd0, bus.Zero}, 32'd1);
    reset = 1'b0;
    repeat (30) @(negedge clk);  // monitor flags any stray out_valid

    // Random traffic with random backpressure
    rand_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      issue(4'($urandom_range(0, 15)), $urandom, $urandom, 1'b1, acc);
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multicycle_alu.md
MULTICYCLE_ALU -- requirements
Module: multicycle_alu

Interface
REQ-001 Parameter: WIDTH, 32, datapath width in bits; only 32 is supported.
REQ-002 clk  input  1  clock; all state changes on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  operation request present.
REQ-005 in_ready  output  1  block can accept a request.
REQ-006 Operation  input  4  ALU operation code, sampled at acceptance.
REQ-007 SrcA  input  WIDTH  first operand, sampled at acceptance.
REQ-008 SrcB  input  WIDTH  second operand or shift amount (bits 4:0), sampled at acceptance.
REQ-009 out_valid  output  1  result available.
REQ-010 out_ready  input  1  consumer takes the result.
REQ-011 ALUResult  output  WIDTH  operation result.
REQ-012 Zero  output  1  high when ALUResult equals 0.

Function
REQ-013 Acceptance SHALL occur on an edge where in_valid && in_ready.
REQ-014 in_ready SHALL be high only in state IDLE.
REQ-015 States SHALL be IDLE, SHIFT and DONE.
REQ-016 Operation decode SHALL be:
- 0000 AND
- 0001 OR
- 0010 ADD
- 0011 SUB
- 0100 XOR
- 0101 SRL
- 0110 SLL
- 0111 SRA
- 1000 EQ (1 if A==B else 0)
- 1010 PASS_B
- 1110 SLT (signed; 1 if A<B else 0)
- any other code: result 0
REQ-017 ADD/SUB SHALL wrap modulo 2^WIDTH; no carry or overflow output.
REQ-018 Non-shift ops: IDLE→DONE on acceptance; result registered the same edge; out_valid high the cycle after acceptance (latency 1).
REQ-019 Shift ops: on acceptance, load shamt=SrcB[4:0] and the working register with SrcA.
- shamt==0: go to DONE with result SrcA.
- shamt!=0: go to SHIFT.
REQ-020 In SHIFT, each cycle SHALL shift the working register by 1 bit (SRL zero-fill, SLL zero-fill, SRA sign-fill) and decrement shamt; on the edge where shamt reaches 0, go to DONE. out_valid latency = 1+shamt cycles.
REQ-021 In DONE, out_valid SHALL be 1 and ALUResult/Zero SHALL hold stable until out_ready; on out_valid && out_ready go to IDLE.
REQ-022 in_valid SHALL be ignored outside IDLE; SrcA/SrcB/Operation changes after acceptance SHALL NOT affect the result.
REQ-023 Zero SHALL be derived from the registered ALUResult.

Reset
REQ-024 reset SHALL force state IDLE, in_ready 1, out_valid 0, ALUResult 0, Zero 1, shamt 0.
REQ-025 reset asserted mid-SHIFT or in DONE SHALL abandon the operation; no out_valid pulse SHALL follow.
REQ-026 reset SHALL take priority over acceptance and handshake on the same edge.

Structure
REQ-027 Shared package alu_pkg SHALL hold:
- alu_op_e enum of the codes in REQ-016
- state enum alu_state_e
- constant SHAMT_W=5
REQ-028 The controller producing Operation SHALL import the same alu_op_e.
REQ-029 One sub-module, alu_shift_step (combinational 1-bit SRL/SLL/SRA step), SHALL be instantiated for the SHIFT state.

Verification
REQ-030 ADD: A=0x00000005, B=0x00000003, accept at cycle 0 -> out_valid at cycle 1, ALUResult=0x00000008, Zero=0.
REQ-031 SUB then EQ: SUB A=B=0x1234 -> ALUResult=0, Zero=1; EQ with the same operands -> ALUResult=1, Zero=0.
REQ-032 SRA: A=0x80000000, B=4 -> out_valid exactly 5 cycles after acceptance, ALUResult=0xF8000000; SLL with B=0 -> latency 1, result A.
REQ-033 Backpressure: out_ready held 0 for 3 cycles in DONE -> ALUResult stable, in_ready 0, in_valid pulses ignored; out_ready=1 -> IDLE the next cycle.
REQ-034 SLT: A=0xFFFFFFFF, B=1 -> result 1; undefined code 1111 -> result 0, Zero=1.
REQ-035 Reset in SHIFT: SLL B=20, reset at cycle 5 -> next cycle IDLE, out_valid 0, ALUResult 0, in_ready 1.
